bg_pixel_fifo: RTL and testbench
================================

Name: bg_pixel_fifo

Overview:
- Background pixel FIFO on the receiving end of the background fetcher's pixel push interface.
- Accepts 8-pixel row pushes from the fetcher and reports when it is empty, which the fetcher uses for its Push2FIFO decision.
- Shifts out one 2-bit colour index per T-cycle towards the pixel mixer.
- Applies SCX fine-scroll discard at line start, flushes on window trigger, tracks the output X position and signals end of line.

Parameters:
- DEPTH, 16, FIFO capacity in pixels; must be a multiple of 8 and at least 8.
- X_MAX, 160, visible pixels per scanline.

Ports:
- clk_in  input  1  100 MHz system clock.
- rst_in  input  1  asynchronous active-high reset.
- tclk_in  input  1  T-cycle enable; all state changes occur only on clk_in edges where tclk_in=1.
- start_line_in  input  1  Mode-3 start pulse; flushes the FIFO and arms discard.
- SCX_in  input  8  scroll X; bits [2:0] are sampled on start_line_in.
- window_trigger_in  input  1  window start; flushes the FIFO and does not change X.
- valid_pixels_in  input  1  push strobe from the fetcher.
- pixels_in  input  2x8 (unpacked [7:0])  element 0 is the leftmost pixel and pops first.
- pop_ena_in  input  1  mixer ready; low while a sprite fetch stalls output.
- empty_out  output  1  count==0; drives the fetcher's bg_fifo_empty_in.
- count_out  output  $clog2(DEPTH+1)  current occupancy.
- pixel_out  output  2  popped colour index.
- pixel_valid_out  output  1  pixel_out holds a visible pixel.
- X_out  output  $clog2(X_MAX)  number of visible pixels emitted this line.
- line_done_out  output  1  pulse, high for one T-cycle after pixel X_MAX-1 is emitted.
- overflow_out  output  1  sticky; set when a push is dropped.

Behaviour:
- Reset (asynchronous):
  - count=0, head=0, state=Idle, discard=0, X_out=0.
  - pixel_out=0, pixel_valid_out=0, line_done_out=0, overflow_out=0, empty_out=1.
- All registers update on posedge clk_in with tclk_in=1. Outputs are registered and hold between T-cycles.
- States: Idle, Discard, Run, Done.
  - Idle/Done: pops are disabled; pushes are still accepted.
  - start_line_in (any state, highest priority):
    - count=0, X_out=0, overflow_out cleared, discard=SCX_in[2:0].
    - Next state is Discard if discard!=0, else Run.
    - A push in the same cycle is ignored.
  - Discard: each pop (count>0 && pop_ena_in) removes the head, keeps pixel_valid_out=0 and decrements discard. Moves to Run when discard reaches 0.
  - Run: each pop removes the head, drives pixel_out=head pixel, sets pixel_valid_out=1 and increments X_out.
    - The pop emitting X_out==X_MAX-1 moves to Done.
    - On that transition: line_done_out=1 for one T-cycle and X_out saturates at X_MAX-1.
- pixel_valid_out is 0 on any T-cycle without a Run-state pop.
- Push:
  - Accepted when valid_pixels_in && count<=DEPTH-8, counting occupancy before any same-cycle pop.
  - The 8 pixels are appended in order pixels_in[0..7].
  - When not accepted, the push is dropped and overflow_out is set.
- Pop: requires count>0 at the start of the cycle. A push into an empty FIFO cannot be popped in the same T-cycle.
- Simultaneous push and pop: count_next = count + 8 - 1, and the head comes from the existing contents.
- window_trigger_in:
  - count=0; same-cycle pops and pushes are discarded.
  - State, X_out and discard are unchanged.
  - Ignored when start_line_in is also high.
- Storage: circular buffer. Head and tail wrap modulo DEPTH; no reordering across the wrap.
- empty_out and count_out reflect the registered count (1-cycle clk_in latency from the T-edge).

Test Plan:
- Reset, start_line_in with SCX=0x00, push pixels {0,1,2,3,0,1,2,3}, pop_ena_in=1 → on the next 8 T-cycles pixel_out=0,1,2,3,0,1,2,3 with pixel_valid_out=1, X_out 1..8, empty_out=1 after the 8th pop.
- SCX=0x05, push {3,3,3,3,3,2,1,0} → first 5 pops give pixel_valid_out=0, then valid pixels 2,1,0, X_out=3.
- count=9 and a push arrives → dropped, overflow_out=1, count 9→8 (with pop). Second push at count=8 with pop → count=15.
- pop_ena_in=0 for 4 T-cycles mid-line → count, X_out and pixel_out held, pixel_valid_out=0. Output resumes with the same next pixel.
- Run 160 visible pops → line_done_out pulses once with X_out=159, state Done; further pushes grow count and produce no pops.
- window_trigger_in at X_out=40 with count=6 → count=0, empty_out=1, X_out stays 40. Next push outputs its pixel[0] at X_out=41.
- Assert rst_in asynchronously mid-line (between tclk edges) → all outputs are at reset values before the next clk_in edge.

Source files
------------

// File: rtl/bg_pixel_fifo.sv
// Background pixel FIFO: takes 8-pixel rows from the fetcher and shifts
// one colour index per T-cycle to the mixer, with fine-scroll discard.
module bg_pixel_fifo #(
  parameter int DEPTH = 16,
  parameter int X_MAX = 160
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       tclk_in,
  input  logic                       start_line_in,
  input  logic [7:0]                 SCX_in,
  input  logic                       window_trigger_in,
  input  logic                       valid_pixels_in,
  input  logic [1:0]                 pixels_in [7:0],
  input  logic                       pop_ena_in,
  output logic                       empty_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out,
  output logic [1:0]                 pixel_out,
  output logic                       pixel_valid_out,
  output logic [$clog2(X_MAX)-1:0]   X_out,
  output logic                       line_done_out,
  output logic                       overflow_out
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam int XW = $clog2(X_MAX);

  typedef enum logic [1:0] {
    IDLE,
    DISCARD,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [1:0]    mem [DEPTH];
  logic [PW-1:0] head;
  logic [CW-1:0] count;
  logic [2:0]    discard;

  logic [PW-1:0] tail;
  logic [PW-1:0] head_nxt;
  logic [PW-1:0] wr_idx [8];
  logic          live;
  logic          pop_ok;
  logic          push_ok;
  logic          drop;

  logic unused_scx;
  assign unused_scx = ^SCX_in[7:3];

  function automatic logic [PW-1:0] wrap(input logic [PW:0] a);
    if (a >= (PW+1)'(DEPTH))
      wrap = PW'(a - (PW+1)'(DEPTH));
    else
      wrap = a[PW-1:0];
  endfunction

  // live: a T-edge not consumed by a line start or window flush
  always_comb begin
    live     = tclk_in && !start_line_in
            && !window_trigger_in;
    pop_ok   = live && pop_ena_in
            && (count != '0)
            && (state == DISCARD || state == RUN);
    push_ok  = live && valid_pixels_in
            && (count <= CW'(DEPTH-8));
    drop     = live && valid_pixels_in
            && (count > CW'(DEPTH-8));
    tail     = wrap({1'b0, head} + (PW+1)'(count));
    head_nxt = wrap({1'b0, head} + (PW+1)'(1));
    for (int i = 0; i < 8; i++)
      wr_idx[i] = wrap({1'b0, tail} + (PW+1)'(i));
  end

  always_ff @(posedge clk_in) begin
    if (push_ok)
      for (int i = 0; i < 8; i++)
        mem[wr_idx[i]] <= pixels_in[i];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state           <= IDLE;
      head            <= '0;
      count           <= '0;
      discard         <= '0;
      X_out           <= '0;
      pixel_out       <= '0;
      pixel_valid_out <= 1'b0;
      line_done_out   <= 1'b0;
      overflow_out    <= 1'b0;
    end else if (tclk_in) begin
      pixel_valid_out <= 1'b0;
      line_done_out   <= 1'b0;
      if (start_line_in) begin
        count        <= '0;
        head         <= '0;
        X_out        <= '0;
        overflow_out <= 1'b0;
        discard      <= SCX_in[2:0];
        state        <= (SCX_in[2:0] != 3'd0)
                      ? DISCARD : RUN;
      end else if (window_trigger_in) begin
        count <= '0;
        head  <= '0;
      end else begin
        if (drop)
          overflow_out <= 1'b1;
        count <= count
               + (push_ok ? CW'(8) : CW'(0))
               - (pop_ok ? CW'(1) : CW'(0));
        if (pop_ok) begin
          head <= head_nxt;
          unique case (1'b1)
            (state == DISCARD): begin
              discard <= discard - 3'd1;
              if (discard == 3'd1)
                state <= RUN;
            end
            (state == RUN): begin
              pixel_out       <= mem[head];
              pixel_valid_out <= 1'b1;
              if (X_out == XW'(X_MAX-1)) begin
                state         <= DONE;
                line_done_out <= 1'b1;
              end else begin
                X_out <= X_out + XW'(1);
              end
            end
          endcase
        end
      end
    end
  end

  assign empty_out = (count == '0);
  assign count_out = count;

endmodule

// File: tb/tb_bg_pixel_fifo.sv
// Directed bench for bg_pixel_fifo: vector table plus
// hand sequences for line end, window flush and async reset.
module tb_bg_pixel_fifo;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       tclk_in;
  logic       start_line_in;
  logic [7:0] SCX_in;
  logic       window_trigger_in;
  logic       valid_pixels_in;
  logic [1:0] px_in [7:0];
  logic       pop_ena_in;
  logic       empty_out;
  logic [4:0] count_out;
  logic [1:0] pixel_out;
  logic       pixel_valid_out;
  logic [7:0] X_out;
  logic       line_done_out;
  logic       overflow_out;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  bg_pixel_fifo #(.DEPTH(16), .X_MAX(160)) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .tclk_in           (tclk_in),
    .start_line_in     (start_line_in),
    .SCX_in            (SCX_in),
    .window_trigger_in (window_trigger_in),
    .valid_pixels_in   (valid_pixels_in),
    .pixels_in         (px_in),
    .pop_ena_in        (pop_ena_in),
    .empty_out         (empty_out),
    .count_out         (count_out),
    .pixel_out         (pixel_out),
    .pixel_valid_out   (pixel_valid_out),
    .X_out             (X_out),
    .line_done_out     (line_done_out),
    .overflow_out      (overflow_out)
  );

  typedef struct packed {
    logic        st;
    logic [7:0]  scx;
    logic        win;
    logic        vld;
    logic [15:0] pix;
    logic        pop;
    logic [4:0]  e_cnt;
    logic [1:0]  e_px;
    logic        e_pv;
    logic [7:0]  e_x;
    logic        e_ov;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  function automatic logic [15:0] pk(
    input logic [1:0] p0, p1, p2, p3,
    input logic [1:0] p4, p5, p6, p7);
    return {p7, p6, p5, p4, p3, p2, p1, p0};
  endfunction

  function automatic logic [1:0] f(input int n);
    return 2'((n * 3 + 1) % 4);
  endfunction

  function automatic vec_t mk(
    input logic st, input logic [7:0] scx,
    input logic win, input logic vld,
    input logic [15:0] pix, input logic pop,
    input int cnt, input int px, input int pv,
    input int x, input int ov);
    vec_t v;
    v.st = st; v.scx = scx; v.win = win;
    v.vld = vld; v.pix = pix; v.pop = pop;
    v.e_cnt = 5'(cnt); v.e_px = 2'(px);
    v.e_pv = 1'(pv); v.e_x = 8'(x);
    v.e_ov = 1'(ov);
    return v;
  endfunction

  task automatic load(input logic [15:0] p);
    for (int i = 0; i < 8; i++)
      px_in[i] = p[2*i +: 2];
  endtask

  task automatic load_f(input int base);
    for (int i = 0; i < 8; i++)
      px_in[i] = f(base + i);
  endtask

  // one T-edge, then one idle clk edge so held outputs are seen
  task automatic tick();
    @(negedge clk_in);
    tclk_in = 1'b1;
    @(posedge clk_in);
    #1;
    tclk_in           = 1'b0;
    start_line_in     = 1'b0;
    window_trigger_in = 1'b0;
    valid_pixels_in   = 1'b0;
    @(posedge clk_in);
    #1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    start_line_in     = v.st;
    SCX_in            = v.scx;
    window_trigger_in = v.win;
    valid_pixels_in   = v.vld;
    load(v.pix);
    pop_ena_in        = v.pop;
    tick();
    chk($sformatf("v%0d count", idx), 32'(count_out), 32'(v.e_cnt));
    chk($sformatf("v%0d empty", idx), 32'(empty_out), 32'(v.e_cnt == 0));
    chk($sformatf("v%0d pixel", idx), 32'(pixel_out), 32'(v.e_px));
    chk($sformatf("v%0d pvalid", idx), 32'(pixel_valid_out), 32'(v.e_pv));
    chk($sformatf("v%0d x", idx), 32'(X_out), 32'(v.e_x));
    chk($sformatf("v%0d ldone", idx), 32'(line_done_out), 32'd0);
    chk($sformatf("v%0d ovf", idx), 32'(overflow_out), 32'(v.e_ov));
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, " count"}, 32'(count_out), 32'd0);
    chk({nm, " empty"}, 32'(empty_out), 32'd1);
    chk({nm, " pixel"}, 32'(pixel_out), 32'd0);
    chk({nm, " pvalid"}, 32'(pixel_valid_out), 32'd0);
    chk({nm, " x"}, 32'(X_out), 32'd0);
    chk({nm, " ldone"}, 32'(line_done_out), 32'd0);
    chk({nm, " ovf"}, 32'(overflow_out), 32'd0);
  endtask

  initial begin
    logic [15:0] a, b, c, d, e, fw;
    logic [1:0]  ea [8];
    logic [1:0]  eb [3];
    logic [1:0]  ec [8];
    logic [1:0]  ed [8];
    logic [1:0]  ee [8];
    int          ld_seen;

    rst_in            = 1'b1;
    tclk_in           = 1'b0;
    start_line_in     = 1'b0;
    SCX_in            = 8'h00;
    window_trigger_in = 1'b0;
    valid_pixels_in   = 1'b0;
    pop_ena_in        = 1'b0;
    load(16'h0000);

    a  = pk(0, 1, 2, 3, 0, 1, 2, 3);
    ea = '{0, 1, 2, 3, 0, 1, 2, 3};
    b  = pk(3, 3, 3, 3, 3, 2, 1, 0);
    eb = '{2, 1, 0};
    c  = pk(1, 2, 3, 0, 1, 2, 3, 0);
    ec = '{1, 2, 3, 0, 1, 2, 3, 0};
    d  = pk(3, 1, 2, 0, 1, 3, 2, 0);
    ed = '{3, 1, 2, 0, 1, 3, 2, 0};
    e  = pk(0, 0, 1, 1, 2, 2, 3, 3);
    ee = '{0, 0, 1, 1, 2, 2, 3, 3};
    fw = pk(2, 0, 0, 0, 0, 0, 0, 1);

    // Idle accepts pushes but never pops
    tbl.push_back(mk(0, 0, 0, 1, a, 1, 8, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 8, 0, 0, 0, 0));
    // SCX=0 line, one row out, then empty pop attempt
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, a, 1, 8, 0, 0, 0, 0));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 7-k, ea[k], 1, k+1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 3, 0, 8, 0));
    // SCX=5 fine-scroll discard
    tbl.push_back(mk(1, 8'h05, 0, 0, 0, 1, 0, 3, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, b, 1, 8, 3, 0, 0, 0));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 7-k, 3, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 2-k, eb[k], 1, k+1, 0));
    // overflow at count 9, accepted push at 8, stall, wrap
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, c, 0, 8, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, d, 1, 15, ec[0], 1, 1, 0));
    for (int k = 1; k < 7; k++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 15-k, ec[k], 1, k+1, 0));
    tbl.push_back(mk(0, 0, 0, 1, e, 1, 8, ec[7], 1, 8, 1));
    tbl.push_back(mk(0, 0, 0, 1, e, 1, 15, ed[0], 1, 9, 1));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 15, ed[0], 0, 9, 1));
    for (int k = 1; k < 8; k++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 15-k, ed[k], 1, 9+k, 1));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 7-k, ee[k], 1, 17+k, 1));

    repeat (3) @(posedge clk_in);
    #1;
    chk_reset("rst");
    @(negedge clk_in);
    rst_in = 1'b0;
    @(posedge clk_in);
    #1;
    chk_reset("post_rst");

    foreach (tbl[i])
      apply(tbl[i], i);

    // full 160-pixel line
    start_line_in = 1'b1;
    SCX_in        = 8'h00;
    pop_ena_in    = 1'b0;
    tick();
    chk("line start ovf", 32'(overflow_out), 32'd0);
    valid_pixels_in = 1'b1;
    load_f(0);
    pop_ena_in = 1'b1;
    tick();
    chk("line first count", 32'(count_out), 32'd8);
    ld_seen = 0;
    for (int i = 0; i < 160; i++) begin
      valid_pixels_in = (i % 8 == 0);
      load_f(i + 8);
      tick();
      ld_seen += int'(line_done_out);
      chk($sformatf("line%0d pixel", i), 32'(pixel_out), 32'(f(i)));
      chk($sformatf("line%0d pvalid", i), 32'(pixel_valid_out), 32'd1);
      chk($sformatf("line%0d x", i), 32'(X_out),
          32'((i < 159) ? i + 1 : 159));
      chk($sformatf("line%0d ldone", i), 32'(line_done_out),
          32'(i == 159));
      chk($sformatf("line%0d count", i), 32'(count_out),
          32'((i % 8 == 0) ? 15 : 15 - (i % 8)));
    end
    valid_pixels_in = 1'b1;
    load_f(0);
    tick();
    ld_seen += int'(line_done_out);
    chk("done push count", 32'(count_out), 32'd16);
    chk("done push pvalid", 32'(pixel_valid_out), 32'd0);
    chk("done push x", 32'(X_out), 32'd159);
    tick();
    ld_seen += int'(line_done_out);
    chk("done hold count", 32'(count_out), 32'd16);
    chk("done hold pvalid", 32'(pixel_valid_out), 32'd0);
    chk("ldone pulses", 32'(ld_seen), 32'd1);

    // window flush at X=40, count=6
    start_line_in = 1'b1;
    SCX_in        = 8'h02;
    pop_ena_in    = 1'b0;
    tick();
    valid_pixels_in = 1'b1;
    load_f(0);
    pop_ena_in = 1'b1;
    tick();
    for (int j = 0; j < 42; j++) begin
      valid_pixels_in = (j % 8 == 0) && (j < 40);
      load_f(j + 8);
      tick();
    end
    chk("win pre x", 32'(X_out), 32'd40);
    chk("win pre count", 32'(count_out), 32'd6);
    chk("win pre pixel", 32'(pixel_out), 32'(f(41)));
    window_trigger_in = 1'b1;
    valid_pixels_in   = 1'b1;
    load(fw);
    tick();
    chk("win count", 32'(count_out), 32'd0);
    chk("win empty", 32'(empty_out), 32'd1);
    chk("win x", 32'(X_out), 32'd40);
    chk("win pvalid", 32'(pixel_valid_out), 32'd0);
    valid_pixels_in = 1'b1;
    load(fw);
    tick();
    chk("win push count", 32'(count_out), 32'd8);
    chk("win push x", 32'(X_out), 32'd40);
    tick();
    chk("win pop pixel", 32'(pixel_out), 32'd2);
    chk("win pop pvalid", 32'(pixel_valid_out), 32'd1);
    chk("win pop x", 32'(X_out), 32'd41);
    chk("win pop count", 32'(count_out), 32'd7);

    // make overflow sticky, then async reset between T-edges
    valid_pixels_in = 1'b1;
    tick();
    chk("pre rst count", 32'(count_out), 32'd14);
    valid_pixels_in = 1'b1;
    tick();
    chk("pre rst ovf", 32'(overflow_out), 32'd1);
    @(negedge clk_in);
    #2;
    rst_in = 1'b1;
    #1;
    chk_reset("async rst");
    @(negedge clk_in);
    rst_in = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
